// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, instruction field positions, state encoding and opcode classifiers for alu_seq_ctrl
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hb;
  localparam logic [3:0] OP_BNE  = 4'hc;
  localparam logic [3:0] OP_HALT = 4'hf;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 8;
  localparam int RS_HI = 7;
  localparam int RS_LO = 4;
  localparam int RT_HI = 3;
  localparam int RT_LO = 0;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;
  function automatic logic is_rtype(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT};
  endfunction
  function automatic logic is_branch(input logic [3:0] op);
    return op == OP_BEQ || op == OP_BNE;
  endfunction
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: combinational opcode to control decode (write-enable, operand-B immediate select, branch type, halt)
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output logic       we,
  output logic       b_imm,
  output logic       br_eq,
  output logic       br_ne,
  output logic       halt
);
  always_comb begin
    we    = is_rtype(op) || op == OP_ADDI;
    b_imm = op == OP_ADDI;
    br_eq = op == OP_BEQ;
    br_ne = op == OP_BNE;
    halt  = op == OP_HALT;
  end
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle fetch/decode/exec/wb sequencer for the 8-bit core; define ALU_SEQ_RETIRE_CNT_EN to add retired_cnt
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              DATA_W   = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [3:0]        rf_raddr_a,
  output logic [3:0]        rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              halted
`ifdef ALU_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]       retired_cnt
`endif
);
  state_t state;
  logic [15:0] ir;
  logic zero_q;
  logic we, b_imm, br_eq, br_ne, halt;
  logic [3:0] op, rd, rs, rt;
  logic [DATA_W-1:0] imm;
  logic [PC_W-1:0] off;
  assign op = ir[OP_HI:OP_LO];
  assign rd = ir[RD_HI:RD_LO];
  assign rs = ir[RS_HI:RS_LO];
  assign rt = ir[RT_HI:RT_LO];
  assign imm = {{(DATA_W-4){rt[3]}}, rt};
  assign off = {{(PC_W-4){rt[3]}}, rt};
  assign imem_addr = pc;
  assign rf_raddr_a = rs;
  assign rf_raddr_b = is_branch(op) ? rd : rt;
  alu_seq_decode u_dec (
    .op   (op),
    .we   (we),
    .b_imm(b_imm),
    .br_eq(br_eq),
    .br_ne(br_ne),
    .halt (halt)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      imem_req   <= 1'b0;
      rf_we      <= 1'b0;
      halted     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      zero_q     <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        FETCH: begin
          if (!imem_req) imem_req <= 1'b1;
          else if (imem_ack) begin
            ir       <= imem_rdata;
            pc       <= pc + 1'b1;
            imem_req <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          alu_a      <= rf_rdata_a;
          alu_b      <= b_imm ? imm : rf_rdata_b;
          alu_opcode <= op;
          state      <= EXEC;
        end
        EXEC: begin
          if (halt) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            rf_wdata <= alu_result;
            zero_q   <= alu_zero;
            rf_waddr <= rd;
            rf_we    <= we;
            state    <= WB;
          end
        end
        WB: begin
          if ((br_eq && zero_q) || (br_ne && !zero_q)) pc <= pc + off;
          imem_req <= 1'b1;
          state    <= FETCH;
        end
        default: ;
      endcase
    end
  end
`ifdef ALU_SEQ_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retired_cnt <= '0;
    else if (state == WB && retired_cnt != 16'hffff) retired_cnt <= retired_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: table-driven and sequence checks of alu_seq_ctrl with a write-back scoreboard
module tb_alu_seq_ctrl;
  logic clk, rst;
  logic imem_req, imem_ack;
  logic [7:0] imem_addr, pc;
  logic [15:0] imem_rdata;
  logic [3:0] rf_raddr_a, rf_raddr_b, alu_opcode, rf_waddr;
  logic [7:0] rf_rdata_a, rf_rdata_b, alu_a, alu_b, alu_res, rf_wdata;
  logic alu_z, rf_we, halted;
`ifdef ALU_SEQ_RETIRE_CNT_EN
  logic [15:0] retired_cnt;
`endif
  logic [15:0] imem [256];
  logic [7:0] regs [16];
  logic [11:0] sb [$];
  logic [11:0] wr_exp;
  logic ack_hi;
  int ack_dly = 0;
  int req_cnt = 0;
  int ntests = 0;
  int nfail = 0;
  typedef struct {
    logic [15:0] instr;
    logic        we;
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic [7:0]  pc;
  } vec_t;
  vec_t vt [17];
  alu_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .rf_raddr_a(rf_raddr_a),
    .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a),
    .rf_rdata_b(rf_rdata_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_opcode(alu_opcode),
    .alu_result(alu_res),
    .alu_zero  (alu_z),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pc        (pc),
    .halted    (halted)
`ifdef ALU_SEQ_RETIRE_CNT_EN
    ,
    .retired_cnt(retired_cnt)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign imem_rdata = imem[imem_addr];
  assign rf_rdata_a = regs[rf_raddr_a];
  assign rf_rdata_b = regs[rf_raddr_b];
  always @(posedge clk) req_cnt <= (imem_req && !imem_ack) ? req_cnt + 1 : 0;
  assign imem_ack = ack_hi || (imem_req && req_cnt >= ack_dly);
  always_comb begin
    case (alu_opcode)
      4'h0, 4'h9:       alu_res = alu_a + alu_b;
      4'h1, 4'hb, 4'hc: alu_res = alu_a - alu_b;
      4'h2:             alu_res = alu_a & alu_b;
      4'h3:             alu_res = alu_a | alu_b;
      4'h4:             alu_res = alu_a ^ alu_b;
      4'h5:             alu_res = {7'd0, $signed(alu_a) < $signed(alu_b)};
      default:          alu_res = 8'h00;
    endcase
  end
  assign alu_z = alu_res == 8'h00;
  always @(negedge clk) begin
    if (rf_we) begin
      ntests++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL wr_unexpected got addr=%0d data=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        wr_exp = sb.pop_front();
        if ({rf_waddr, rf_wdata} !== wr_exp) begin
          nfail++;
          $display("FAIL wr_data got addr=%0d data=%h, required addr=%0d data=%h", rf_waddr, rf_wdata, wr_exp[11:8], wr_exp[7:0]);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h required=%h", nm, got, exp);
    end
  endtask
  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h7000;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_fetch(input logic [7:0] a);
    int n = 0;
    @(negedge clk);
    while (!(imem_req && imem_ack && imem_addr == a) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_wait", n < 300, 1);
  endtask
  task automatic wait_drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n < 30, 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    ack_hi = 1'b1;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    regs[1] = 8'h03;
    regs[2] = 8'h05;
    regs[3] = 8'h80;
    regs[4] = 8'h7f;
    regs[5] = 8'h05;
    clear_imem();
    vt[0]  = '{16'h0312, 1'b1, 4'd3,  8'h08, 8'h01};
    vt[1]  = '{16'h1512, 1'b1, 4'd5,  8'hfe, 8'h01};
    vt[2]  = '{16'h2612, 1'b1, 4'd6,  8'h01, 8'h01};
    vt[3]  = '{16'h3712, 1'b1, 4'd7,  8'h07, 8'h01};
    vt[4]  = '{16'h4812, 1'b1, 4'd8,  8'h06, 8'h01};
    vt[5]  = '{16'h5912, 1'b1, 4'd9,  8'h01, 8'h01};
    vt[6]  = '{16'h5a34, 1'b1, 4'd10, 8'h01, 8'h01};
    vt[7]  = '{16'h9a17, 1'b1, 4'd10, 8'h0a, 8'h01};
    vt[8]  = '{16'h940f, 1'b1, 4'd4,  8'hff, 8'h01};
    vt[9]  = '{16'h0012, 1'b1, 4'd0,  8'h08, 8'h01};
    vt[10] = '{16'hb11e, 1'b0, 4'd0,  8'h00, 8'hff};
    vt[11] = '{16'hc11e, 1'b0, 4'd0,  8'h00, 8'h01};
    vt[12] = '{16'hb12e, 1'b0, 4'd0,  8'h00, 8'h01};
    vt[13] = '{16'hc123, 1'b0, 4'd0,  8'h00, 8'h04};
    vt[14] = '{16'hb557, 1'b0, 4'd0,  8'h00, 8'h08};
    vt[15] = '{16'h7000, 1'b0, 4'd0,  8'h00, 8'h01};
    vt[16] = '{16'he123, 1'b0, 4'd0,  8'h00, 8'h01};
    @(negedge clk);
    chk("rst_outputs", {imem_req, rf_we, halted, alu_a, alu_b, alu_opcode, rf_waddr, rf_wdata, pc}, 64'd0);
    for (int v = 0; v < 17; v++) begin
      clear_imem();
      imem[0] = vt[v].instr;
      do_reset();
      if (vt[v].we) sb.push_back({vt[v].wa, vt[v].wd});
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_pc", v), pc, vt[v].pc);
      chk($sformatf("vec%0d_wr_done", v), sb.size(), 0);
    end
    clear_imem();
    imem[0] = 16'h0312;
    do_reset();
    sb.push_back({4'd3, 8'h08});
    @(posedge clk);
    @(negedge clk);
    chk("lat_req_rise", {imem_req, rf_we}, 2'b10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lat_no_early_we", rf_we, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_we_cycle4", {rf_we, pc}, {1'b1, 8'h01});
    clear_imem();
    imem[0] = 16'h0312;
    ack_hi = 1'b0;
    ack_dly = 5;
    do_reset();
    sb.push_back({4'd3, 8'h08});
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("dly_hold%0d", i), {imem_req, imem_ack, rf_we, imem_addr}, {3'b100, 8'h00});
    end
    wait_drain("dly_wr");
    ack_hi = 1'b1;
    clear_imem();
    imem[4] = 16'hb11e;
    do_reset();
    wait_fetch(8'h04);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("beq_taken_pc", pc, 8'h03);
    imem[4] = 16'hc11e;
    do_reset();
    wait_fetch(8'h04);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bne_fall_pc", pc, 8'h05);
    clear_imem();
    imem[0] = 16'hb11e;
    do_reset();
    wait_fetch(8'h00);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("wrap_pc_ff", pc, 8'hff);
    wait_fetch(8'hff);
    @(posedge clk);
    @(negedge clk);
    chk("wrap_pc_00", pc, 8'h00);
    clear_imem();
    imem[0] = 16'hf000;
    do_reset();
    wait_fetch(8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("halt_set", halted, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("halt_idle%0d", i), {halted, imem_req, rf_we, pc}, {3'b100, 8'h01});
    end
    #2 rst = 1'b1;
    #1 chk("halt_async_rst", {halted, pc}, 9'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("halt_refetch", {imem_req, imem_addr}, {1'b1, 8'h00});
    clear_imem();
    imem[0] = 16'h0312;
    do_reset();
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("wb_abort", {rf_we, pc}, 9'd0);
    clear_imem();
    imem[0] = 16'h0312;
    imem[2] = 16'hb12e;
    imem[3] = 16'hf000;
    do_reset();
`ifdef ALU_SEQ_RETIRE_CNT_EN
    chk("ret_zero", retired_cnt, 0);
`endif
    sb.push_back({4'd3, 8'h08});
    begin
      int n = 0;
      while (!halted && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("ret_halt_wait", n < 100, 1);
    end
    chk("ret_pc", pc, 8'h04);
`ifdef ALU_SEQ_RETIRE_CNT_EN
    chk("ret_cnt3", retired_cnt, 3);
`endif
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
